// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word-aligned memory request at a time and
// queues responses in a two-entry FIFO presented to the datapath.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | after reset; copy initialPCval into the fetch PC
// FETCH    | idle; issue a request when unpaused and the buffer has room
// WAIT_ACK | request outstanding; push the response on imem_ack
// DROP     | request outstanding but redirected; discard the response
module instruction_fetch #(
   parameter logic [31:0] NOP_WORD  = 32'h00000013,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] initialPCval,
   input  logic        pause,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_word,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   typedef enum logic [1:0] {LOAD, FETCH, WAIT_ACK, DROP} state_e;

   localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        head_q, head_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] ent_pc_q   [BUF_DEPTH];
   logic [31:0] ent_data_q [BUF_DEPTH];

   logic        redirect_act;
   logic        buf_valid;
   logic        pop;
   logic        push;
   logic        issue;
   logic [1:0]  occ_after_pop;
   logic        wr_idx;
   logic        unused_lsbs;

   assign unused_lsbs = ^{initialPCval[1:0], redirect_pc[1:0]};

   assign redirect_act  = redirect && (state_q != LOAD);
   assign buf_valid     = (cnt_q != 2'd0) && !pause && !redirect_act;
   assign pop           = buf_valid && instr_ready;
   assign occ_after_pop = cnt_q - {1'b0, pop};
   // Room is judged after this cycle's pop so a full buffer being drained can still issue.
   assign issue         = (state_q == FETCH) && !pause && !redirect && (occ_after_pop < FULL_CNT);
   assign push          = (state_q == WAIT_ACK) && imem_ack && !redirect;
   assign wr_idx        = head_q ^ cnt_q[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:     state_d = FETCH;
         FETCH:    if (issue) state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (imem_ack) begin
               state_d = FETCH;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP:     if (imem_ack) state_d = FETCH;
         default:  state_d = LOAD;
      endcase
   end

   always_comb begin
      imem_req         = 1'b0;
      imem_addr        = '0;
      unique case (state_q)
         FETCH: begin
            if (issue) begin
               imem_req  = 1'b1;
               imem_addr = pc_q;
            end
         end
         WAIT_ACK, DROP: begin
            imem_req  = 1'b1;
            imem_addr = req_addr_q;
         end
         default: ;
      endcase
      instr_valid      = buf_valid;
      instruction_word = NOP_WORD;
      instr_pc         = '0;
      if (buf_valid) begin
         instruction_word = ent_data_q[head_q];
         instr_pc         = ent_pc_q[head_q];
      end
   end

   always_comb begin
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      head_d     = head_q;
      cnt_d      = cnt_q;
      if (state_q == LOAD) begin
         pc_d = {initialPCval[31:2], 2'b00};
      end else if (redirect) begin
         pc_d   = {redirect_pc[31:2], 2'b00};
         head_d = 1'b0;
         cnt_d  = 2'd0;
      end else begin
         if (push) begin
            pc_d = pc_q + 32'd4;
         end
         head_d = head_q ^ pop;
         cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      end
      if (issue) begin
         req_addr_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= '0;
         req_addr_q <= '0;
         head_q     <= 1'b0;
         cnt_q      <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            ent_pc_q[i]   <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         head_q     <= head_d;
         cnt_q      <= cnt_d;
         if (push) begin
            ent_pc_q[wr_idx]   <= pc_q;
            ent_data_q[wr_idx] <= imem_rdata;
         end
      end
   end

endmodule
